// File: rtl/uart_debug_sched_pkg.sv
// Shared constants and types for the UART debug-mux snapshot scheduler.
// Build option: define UART_DEBUG_SCHED_TSTAMP_EN to append a 32-bit
// cycle timestamp word (tag 2) to every snapshot.
package uart_debug_sched_pkg;

  localparam int ADDR_W  = 5;
  localparam int TRACE_W = 34;

  // Debug mux word addresses
  localparam logic [ADDR_W-1:0] DBG_ADR0 = 5'b01000;
  localparam logic [ADDR_W-1:0] DBG_ADR1 = 5'b01100;

  // Snapshot FSM encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD0  = 2'd1;
  localparam logic [1:0] S_RD1  = 2'd2;
  localparam logic [1:0] S_RD2  = 2'd3;

  // Trace word tags
  localparam logic [1:0] TAG_W0 = 2'd0;
  localparam logic [1:0] TAG_W1 = 2'd1;
  localparam logic [1:0] TAG_TS = 2'd2;

`ifdef UART_DEBUG_SCHED_TSTAMP_EN
  localparam int NWORDS = 3;
`else
  localparam int NWORDS = 2;
`endif

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } trace_t;

endpackage

// File: rtl/uart_debug_fifo.sv
// First-word-fall-through trace FIFO (tag+data words) with occupancy count.
// The writer reserves space before pushing, so no overflow guard is needed.
module uart_debug_fifo
  import uart_debug_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               wb_rst_ni,
  input  logic               push,
  input  logic [TRACE_W-1:0] push_data,
  input  logic               pop,
  output logic [TRACE_W-1:0] head,
  output logic               valid,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TRACE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  // Storage array; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_debug_sched.sv
// Snapshot scheduler sharing the UART debug-mux address with the host.
// Periodic ticks or triggers capture both debug words into a trace FIFO.
// Build option: UART_DEBUG_SCHED_TSTAMP_EN adds a timestamp word (RD2).
module uart_debug_sched
  import uart_debug_sched_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                wb_rst_ni,
  input  logic                enable_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                trig_i,
  input  logic                host_req_i,
  input  logic [ADDR_W-1:0]   host_adr_i,
  output logic [ADDR_W-1:0]   dbg_adr_o,
  input  logic [31:0]         dbg_dat_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_data_o,
  output logic [1:0]          out_tag_o,
  output logic                busy_o,
  output logic [7:0]          drop_cnt_o,
  input  logic                clr_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PERIOD_W-1:0] per_cnt;
  logic                per_on, per_last, tick;
  logic                pending, space_ok, start, drop, push;
  logic [1:0]          state, state_nxt;
  logic [CNT_W-1:0]    fifo_cnt;
  trace_t              push_word, head_word;

  assign per_on   = enable_i && (period_i != '0);
  // >= keeps the counter bounded if period_i shrinks mid-count
  assign per_last = (per_cnt >= period_i - PERIOD_W'(1));
  assign tick     = per_on & per_last;

  // A snapshot only starts when all of its words are guaranteed to fit
  assign space_ok = (DEPTH - int'(fifo_cnt)) >= NWORDS;
  assign start    = (state == S_IDLE) & pending & space_ok;
  assign drop     = (state == S_IDLE) & pending & ~space_ok;
  // Host access stalls capture: the mux is showing the host's address
  assign push     = (state != S_IDLE) & ~host_req_i;
  assign busy_o   = (state != S_IDLE);

  // Period counter: 0..period-1, held at 0 when disabled
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)             per_cnt <= '0;
    else if (!per_on || per_last) per_cnt <= '0;
    else                        per_cnt <= per_cnt + PERIOD_W'(1);
  end

  // Coalescing request flag; a new request at the start edge survives
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)            pending <= 1'b0;
    else if (!enable_i)        pending <= 1'b0;
    else if (trig_i || tick)   pending <= 1'b1;
    else if (state == S_IDLE)  pending <= 1'b0;
  end

  // Saturating drop counter; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                       drop_cnt_o <= '0;
    else if (clr_i)                       drop_cnt_o <= '0;
    else if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
  end

  // Snapshot FSM state register
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state: each read state advances only when the host is idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)       state_nxt = S_RD0;
      S_RD0:  if (!host_req_i) state_nxt = S_RD1;
`ifdef UART_DEBUG_SCHED_TSTAMP_EN
      S_RD1:  if (!host_req_i) state_nxt = S_RD2;
      S_RD2:  if (!host_req_i) state_nxt = S_IDLE;
`else
      S_RD1:  if (!host_req_i) state_nxt = S_IDLE;
`endif
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Mux address: host first, then the word the current state is reading
  always_comb begin
    dbg_adr_o = host_adr_i;
    if (!host_req_i) begin
      case (state)
        S_RD0:   dbg_adr_o = DBG_ADR0;
        S_RD1:   dbg_adr_o = DBG_ADR1;
        S_RD2:   dbg_adr_o = DBG_ADR0;
        default: dbg_adr_o = host_adr_i;
      endcase
    end
  end

`ifdef UART_DEBUG_SCHED_TSTAMP_EN
  logic [31:0] ts_cnt, ts_q;

  // Free-running cycle counter, sampled when a snapshot begins
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (start) ts_q <= ts_cnt;
    end
  end
`endif

  // Trace word for the current read state
  always_comb begin
    push_word.tag  = TAG_W0;
    push_word.data = dbg_dat_i;
    case (state)
      S_RD1: push_word.tag = TAG_W1;
`ifdef UART_DEBUG_SCHED_TSTAMP_EN
      S_RD2: begin
        push_word.tag  = TAG_TS;
        push_word.data = ts_q;
      end
`endif
      default: ;
    endcase
  end

  uart_debug_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .wb_rst_ni (wb_rst_ni),
    .push      (push),
    .push_data (push_word),
    .pop       (out_ready_i),
    .head      (head_word),
    .valid     (out_valid_o),
    .count     (fifo_cnt)
  );

  assign out_data_o = head_word.data;
  assign out_tag_o  = head_word.tag;

endmodule

// File: tb/tb_uart_debug_sched.sv
// Directed bench for uart_debug_sched (default build: two words per snapshot).
module tb_uart_debug_sched;

  logic        clk = 1'b0, wb_rst_ni = 1'b0;
  logic        enable_i = 1'b0, trig_i = 1'b0, host_req_i = 1'b0;
  logic        out_ready_i = 1'b0, clr_i = 1'b0;
  logic [15:0] period_i = '0;
  logic [4:0]  host_adr_i = 5'b00010;
  logic [4:0]  dbg_adr_o;
  logic [31:0] dbg_dat_i, out_data_o;
  logic        out_valid_o, busy_o;
  logic [1:0]  out_tag_o;
  logic [7:0]  drop_cnt_o;

  logic [31:0] d0 = '0, d1 = '0;
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [33:0] got_q[$];
  int          t0_q[$];

  uart_debug_sched dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .enable_i(enable_i), .period_i(period_i),
    .trig_i(trig_i), .host_req_i(host_req_i), .host_adr_i(host_adr_i),
    .dbg_adr_o(dbg_adr_o), .dbg_dat_i(dbg_dat_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_tag_o(out_tag_o),
    .busy_o(busy_o), .drop_cnt_o(drop_cnt_o), .clr_i(clr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Debug mux model: distinct words per address, host data elsewhere
  assign dbg_dat_i = (dbg_adr_o == 5'b01000) ? d0 :
                     (dbg_adr_o == 5'b01100) ? d1 : {27'h2AAAAAA, dbg_adr_o};

  // Record every accepted trace word
  always @(negedge clk) begin
    if (wb_rst_ni && out_valid_o && out_ready_i) begin
      got_q.push_back({out_tag_o, out_data_o});
      if (out_tag_o == 2'd0) t0_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bad;
    step(3);
    chk("rst_valid_in", out_valid_o, 0);
    chk("rst_busy_in", busy_o, 0);
    wb_rst_ni = 1'b1; #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_adr_pass", dbg_adr_o, 5'b00010);

    // Single trigger: words appear 2 cycles after trig, busy 2 cycles
    enable_i = 1; out_ready_i = 1;
    d0 = 32'h1F03C160; d1 = 32'h0000ABCD;
    trig_i = 1; step(); trig_i = 0; #1;
    chk("t1_busy_e0", busy_o, 0);
    chk("t1_valid_e0", out_valid_o, 0);
    step();
    chk("t1_busy_e1", busy_o, 1);
    chk("t1_valid_e1", out_valid_o, 0);
    chk("t1_adr_rd0", dbg_adr_o, 5'b01000);
    step();
    chk("t1_busy_e2", busy_o, 1);
    chk("t1_valid_e2", out_valid_o, 1);
    chk("t1_tag0", out_tag_o, 0);
    chk("t1_dat0", out_data_o, d0);
    chk("t1_adr_rd1", dbg_adr_o, 5'b01100);
    step();
    chk("t1_busy_e3", busy_o, 0);
    chk("t1_tag1", out_tag_o, 1);
    chk("t1_dat1", out_data_o, d1);
    step();
    chk("t1_valid_e4", out_valid_o, 0);
    chk("t1_nwords", got_q.size(), 2);

    // Periodic: period 10 for 100 cycles -> 10 snapshots, 10 cycles apart
    got_q.delete(); t0_q.delete();
    period_i = 16'd10;
    step(100);
    enable_i = 0; period_i = 0;
    step(10);
    chk("t2_nwords", got_q.size(), 20);
    bad = 0;
    foreach (got_q[i]) if (got_q[i][33:32] != 2'(i % 2)) bad++;
    chk("t2_tag_order", bad, 0);
    bad = 0;
    for (int i = 1; i < t0_q.size(); i++) if (t0_q[i] - t0_q[i-1] != 10) bad++;
    chk("t2_tick_gap", bad, 0);

    // Host stall during RD0 for 3 cycles
    got_q.delete(); enable_i = 1;
    d0 = 32'hCAFE0001; d1 = 32'hCAFE0002;
    trig_i = 1; step(); trig_i = 0; step();
    host_req_i = 1; host_adr_i = 5'b00011; #1;
    chk("t3_adr_host0", dbg_adr_o, 5'b00011);
    step();
    chk("t3_adr_host1", dbg_adr_o, 5'b00011);
    chk("t3_nopush1", out_valid_o, 0);
    chk("t3_busy1", busy_o, 1);
    step();
    chk("t3_nopush2", out_valid_o, 0);
    step();
    host_req_i = 0; #1;
    chk("t3_nopush3", out_valid_o, 0);
    chk("t3_adr_rd0", dbg_adr_o, 5'b01000);
    step();
    chk("t3_valid", out_valid_o, 1);
    chk("t3_w0", {out_tag_o, out_data_o}, {2'd0, d0});
    step();
    chk("t3_w1", {out_tag_o, out_data_o}, {2'd1, d1});
    step(3);
    chk("t3_nwords", got_q.size(), 2);

    // Overflow: 3 triggers 5 cycles apart with consumer stalled
    got_q.delete(); out_ready_i = 0; host_adr_i = 5'b00010;
    d0 = 32'h00000A0A; d1 = 32'h00000B0B;
    trig_i = 1; step(); trig_i = 0; step(4);
    d0 = 32'h00000C0C; d1 = 32'h00000D0D;
    trig_i = 1; step(); trig_i = 0; step(4);
    d0 = 32'h00000E0E; d1 = 32'h00000F0F;
    trig_i = 1; step(); trig_i = 0; step(4);
    chk("t4_drop1", drop_cnt_o, 1);
    chk("t4_busy", busy_o, 0);
    chk("t4_head", {out_tag_o, out_data_o}, {2'd0, 32'h00000A0A});
    clr_i = 1; step(); clr_i = 0; #1;
    chk("t4_clr", drop_cnt_o, 0);
    out_ready_i = 1; step(6);
    chk("t4_nwords", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t4_q1", got_q[1], {2'd1, 32'h00000B0B});
      chk("t4_q2", got_q[2], {2'd0, 32'h00000C0C});
      chk("t4_q3", got_q[3], {2'd1, 32'h00000D0D});
    end

    // Coalescing: trig + tick both during busy -> one extra snapshot
    got_q.delete();
    d0 = 32'h11110000; d1 = 32'h22220000;
    trig_i = 1; period_i = 16'd3; step();
    trig_i = 0; step();
    trig_i = 1; step();
    trig_i = 0; period_i = 0;
    step(10);
    chk("t5_nwords", got_q.size(), 4);
    chk("t5_drop", drop_cnt_o, 0);

    // Saturation: trigger held with consumer stalled
    got_q.delete(); out_ready_i = 0; trig_i = 1;
    step(310);
    chk("t6_sat", drop_cnt_o, 255);
    clr_i = 1; step(); clr_i = 0; trig_i = 0; #1;
    chk("t6_clr_prio", drop_cnt_o, 0);
    step();
    chk("t6_last_drop", drop_cnt_o, 1);
    step(3);
    chk("t6_hold", drop_cnt_o, 1);

    // Reset mid-snapshot (in RD1)
    out_ready_i = 1; step(6);
    got_q.delete();
    d0 = 32'h33330000; d1 = 32'h44440000;
    trig_i = 1; step(); trig_i = 0; step(2);
    chk("t7_pre_valid", out_valid_o, 1);
    chk("t7_pre_busy", busy_o, 1);
    wb_rst_ni = 0; #1;
    chk("t7_rst_valid", out_valid_o, 0);
    chk("t7_rst_busy", busy_o, 0);
    chk("t7_rst_drop", drop_cnt_o, 0);
    step(2);
    wb_rst_ni = 1;
    step(5);
    chk("t7_post_valid", out_valid_o, 0);
    chk("t7_post_busy", busy_o, 0);
    chk("t7_no_residual", got_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
